// File: rtl/continuous_monitoring_system_pkg.sv
// rtl/continuous_monitoring_system_pkg.sv - shared types and constants for the CMS control port
package continuous_monitoring_system_pkg;

    localparam int CTRL_ADDR_WIDTH      = 8;
    localparam int CTRL_DATA_WIDTH      = 64;
    localparam int CLK_COUNTER_WIDTH    = 64;
    localparam int NO_OF_CTRL_REGISTERS = 11;

    localparam logic [31:0] WFI_INSTRUCTION = 32'h1050_0073;

    typedef enum logic [CTRL_ADDR_WIDTH-1:0] {
        TRIGGER_TRACE_START_ADDRESS_ENABLED       = 8'd0,
        TRIGGER_TRACE_START_ADDRESS               = 8'd1,
        TRIGGER_TRACE_END_ADDRESS_ENABLED         = 8'd2,
        TRIGGER_TRACE_END_ADDRESS                 = 8'd3,
        MONITOR_ADDRESS_RANGE_LOWER_BOUND_ENABLED = 8'd4,
        MONITOR_ADDRESS_RANGE_LOWER_BOUND         = 8'd5,
        MONITOR_ADDRESS_RANGE_UPPER_BOUND_ENABLED = 8'd6,
        MONITOR_ADDRESS_RANGE_UPPER_BOUND         = 8'd7,
        WFI_STOPPED                               = 8'd8,
        CLK_COUNTER                               = 8'd9,
        LAST_WRITE_TIMESTAMP                      = 8'd10
    } ctrl_addr_t;

    typedef struct packed {
        logic [CTRL_DATA_WIDTH-1:0] rdata;
        logic                       rvalid;
        logic                       addr_error;
    } ctrl_rsp_t;

endpackage

// File: rtl/cms_ctrl_regfile_if.sv
// rtl/cms_ctrl_regfile_if.sv - host control port bundle with host and responder views
interface cms_ctrl_regfile_if
    import continuous_monitoring_system_pkg::*;
#(
    parameter int ADDR_WIDTH = CTRL_ADDR_WIDTH,
    parameter int DATA_WIDTH = CTRL_DATA_WIDTH
);
    logic [ADDR_WIDTH-1:0] ctrl_addr;
    logic [DATA_WIDTH-1:0] ctrl_wdata;
    logic                  ctrl_write_enable;
    logic                  ctrl_read_enable;
    logic [DATA_WIDTH-1:0] ctrl_rdata;
    logic                  ctrl_rvalid;
    logic                  ctrl_addr_error;

    modport master (
        output ctrl_addr, ctrl_wdata, ctrl_write_enable, ctrl_read_enable,
        input  ctrl_rdata, ctrl_rvalid, ctrl_addr_error
    );

    modport slave (
        input  ctrl_addr, ctrl_wdata, ctrl_write_enable, ctrl_read_enable,
        output ctrl_rdata, ctrl_rvalid, ctrl_addr_error
    );
endinterface

// File: rtl/cms_clk_counter.sv
// rtl/cms_clk_counter.sv - free-running wrap-around cycle counter with load and freeze
module cms_clk_counter #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             freeze,
    output logic [WIDTH-1:0] count
);

    // A host load takes priority even while frozen so software can rebase the counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (!freeze) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/cms_ctrl_regfile.sv
// rtl/cms_ctrl_regfile.sv - CMS control register file: trigger/range config, counter, WFI flag
module cms_ctrl_regfile
    import continuous_monitoring_system_pkg::*;
#(
    parameter int ADDR_WIDTH    = CTRL_ADDR_WIDTH,
    parameter int DATA_WIDTH    = CTRL_DATA_WIDTH,
    parameter int CNT_WIDTH     = CLK_COUNTER_WIDTH,
    parameter bit FREEZE_ON_WFI = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    cms_ctrl_regfile_if.slave     ctrl,
    input  logic [31:0]           instr,
    input  logic                  instr_valid,
    output logic                  trace_start_en,
    output logic                  trace_end_en,
    output logic [DATA_WIDTH-1:0] trace_start_addr,
    output logic [DATA_WIDTH-1:0] trace_end_addr,
    output logic                  range_lower_en,
    output logic                  range_upper_en,
    output logic [DATA_WIDTH-1:0] range_lower,
    output logic [DATA_WIDTH-1:0] range_upper,
    output logic                  wfi_stopped,
    output logic [CNT_WIDTH-1:0]  clk_counter
);

    logic                  addr_defined;
    ctrl_addr_t            reg_sel;
    logic                  wr;
    logic                  rd;
    logic                  wfi_set;
    logic                  counter_load;
    logic [CNT_WIDTH-1:0]  last_write_ts;
    logic [DATA_WIDTH-1:0] rdata_mux;
    ctrl_rsp_t             rsp_d;
    ctrl_rsp_t             rsp_q;

    assign addr_defined = ctrl.ctrl_addr < ADDR_WIDTH'(NO_OF_CTRL_REGISTERS);
    assign reg_sel      = ctrl_addr_t'(CTRL_ADDR_WIDTH'(ctrl.ctrl_addr));
    assign wr           = ctrl.ctrl_write_enable && addr_defined;
    assign rd           = ctrl.ctrl_read_enable && addr_defined;
    assign wfi_set      = instr_valid && (instr == WFI_INSTRUCTION);
    assign counter_load = wr && (reg_sel == CLK_COUNTER);

    cms_clk_counter #(
        .WIDTH (CNT_WIDTH)
    ) u_clk_counter (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (counter_load),
        .load_value (CNT_WIDTH'(ctrl.ctrl_wdata)),
        .freeze     (FREEZE_ON_WFI && wfi_stopped),
        .count      (clk_counter)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trace_start_en   <= 1'b0;
            trace_end_en     <= 1'b0;
            trace_start_addr <= '0;
            trace_end_addr   <= '0;
            range_lower_en   <= 1'b0;
            range_upper_en   <= 1'b0;
            range_lower      <= '0;
            range_upper      <= '0;
        end else if (wr) begin
            case (reg_sel)
                TRIGGER_TRACE_START_ADDRESS_ENABLED:       trace_start_en   <= ctrl.ctrl_wdata[0];
                TRIGGER_TRACE_START_ADDRESS:               trace_start_addr <= ctrl.ctrl_wdata;
                TRIGGER_TRACE_END_ADDRESS_ENABLED:         trace_end_en     <= ctrl.ctrl_wdata[0];
                TRIGGER_TRACE_END_ADDRESS:                 trace_end_addr   <= ctrl.ctrl_wdata;
                MONITOR_ADDRESS_RANGE_LOWER_BOUND_ENABLED: range_lower_en   <= ctrl.ctrl_wdata[0];
                MONITOR_ADDRESS_RANGE_LOWER_BOUND:         range_lower      <= ctrl.ctrl_wdata;
                MONITOR_ADDRESS_RANGE_UPPER_BOUND_ENABLED: range_upper_en   <= ctrl.ctrl_wdata[0];
                MONITOR_ADDRESS_RANGE_UPPER_BOUND:         range_upper      <= ctrl.ctrl_wdata;
                default: ;
            endcase
        end
    end

    // Timestamp covers every defined write, including the ignored one to the timestamp itself.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_write_ts <= '0;
        end else if (wr) begin
            last_write_ts <= clk_counter;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wfi_stopped <= 1'b0;
        end else if (wfi_set) begin
            wfi_stopped <= 1'b1;
        end else if (wr && (reg_sel == WFI_STOPPED)) begin
            wfi_stopped <= ctrl.ctrl_wdata[0];
        end
    end

    always_comb begin
        rdata_mux = '0;
        case (reg_sel)
            TRIGGER_TRACE_START_ADDRESS_ENABLED:       rdata_mux = DATA_WIDTH'(trace_start_en);
            TRIGGER_TRACE_START_ADDRESS:               rdata_mux = trace_start_addr;
            TRIGGER_TRACE_END_ADDRESS_ENABLED:         rdata_mux = DATA_WIDTH'(trace_end_en);
            TRIGGER_TRACE_END_ADDRESS:                 rdata_mux = trace_end_addr;
            MONITOR_ADDRESS_RANGE_LOWER_BOUND_ENABLED: rdata_mux = DATA_WIDTH'(range_lower_en);
            MONITOR_ADDRESS_RANGE_LOWER_BOUND:         rdata_mux = range_lower;
            MONITOR_ADDRESS_RANGE_UPPER_BOUND_ENABLED: rdata_mux = DATA_WIDTH'(range_upper_en);
            MONITOR_ADDRESS_RANGE_UPPER_BOUND:         rdata_mux = range_upper;
            WFI_STOPPED:                               rdata_mux = DATA_WIDTH'(wfi_stopped);
            CLK_COUNTER:                               rdata_mux = DATA_WIDTH'(clk_counter);
            LAST_WRITE_TIMESTAMP:                      rdata_mux = DATA_WIDTH'(last_write_ts);
            default:                                   rdata_mux = '0;
        endcase
    end

    // Read and write share one address, so a bad address yields one error pulse.
    always_comb begin
        rsp_d            = '0;
        rsp_d.rdata      = rd ? CTRL_DATA_WIDTH'(rdata_mux) : '0;
        rsp_d.rvalid     = ctrl.ctrl_read_enable;
        rsp_d.addr_error = (ctrl.ctrl_write_enable || ctrl.ctrl_read_enable) && !addr_defined;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_q <= '0;
        end else begin
            rsp_q <= rsp_d;
        end
    end

    assign ctrl.ctrl_rdata      = DATA_WIDTH'(rsp_q.rdata);
    assign ctrl.ctrl_rvalid     = rsp_q.rvalid;
    assign ctrl.ctrl_addr_error = rsp_q.addr_error;

endmodule

// File: tb/tb_cms_ctrl_regfile.sv
// tb/tb_cms_ctrl_regfile.sv - directed self-checking bench for cms_ctrl_regfile
module tb_cms_ctrl_regfile;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] instr = '0;
    logic        instr_valid = 1'b0;
    logic        trace_start_en, trace_end_en, range_lower_en, range_upper_en, wfi_stopped;
    logic [63:0] trace_start_addr, trace_end_addr, range_lower, range_upper, clk_counter;

    int          errors = 0;
    int          checks = 0;
    logic [63:0] cnt;
    logic [63:0] ts_exp;
    logic [63:0] c_frz;
    bit          wfi_m;

    cms_ctrl_regfile_if bus ();

    cms_ctrl_regfile dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .ctrl             (bus),
        .instr            (instr),
        .instr_valid      (instr_valid),
        .trace_start_en   (trace_start_en),
        .trace_end_en     (trace_end_en),
        .trace_start_addr (trace_start_addr),
        .trace_end_addr   (trace_end_addr),
        .range_lower_en   (range_lower_en),
        .range_upper_en   (range_upper_en),
        .range_lower      (range_lower),
        .range_upper      (range_upper),
        .wfi_stopped      (wfi_stopped),
        .clk_counter      (clk_counter)
    );

    always #5 clk = ~clk;

    // One bus cycle; keeps the expected counter, timestamp and WFI flag alongside.
    task automatic step(input bit we, input bit re, input logic [7:0] a,
                        input logic [63:0] d, input bit wfi_i);
        bus.ctrl_write_enable = we;
        bus.ctrl_read_enable  = re;
        bus.ctrl_addr         = a;
        bus.ctrl_wdata        = d;
        instr_valid           = wfi_i;
        instr                 = wfi_i ? 32'h1050_0073 : 32'h0000_0013;
        if (we && a < 8'd11) ts_exp = cnt;
        if (we && a == 8'd9) cnt = d;
        else if (!wfi_m) cnt = cnt + 64'd1;
        if (wfi_i) wfi_m = 1'b1;
        else if (we && a == 8'd8) wfi_m = d[0];
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.ctrl_write_enable = 1'b0;
        bus.ctrl_read_enable  = 1'b0;
        bus.ctrl_addr         = '0;
        bus.ctrl_wdata        = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({bus.ctrl_rvalid, bus.ctrl_addr_error, wfi_stopped, trace_start_en, trace_end_en,
             range_lower_en, range_upper_en} !== 7'b0 || clk_counter !== 64'd0 ||
            (trace_start_addr | trace_end_addr | range_lower | range_upper | bus.ctrl_rdata) !== 64'd0) begin
            errors++;
            $display("FAIL reset_state: rvalid=%b err=%b cnt=%h tsa=%h", bus.ctrl_rvalid,
                     bus.ctrl_addr_error, clk_counter, trace_start_addr);
        end
        rst_n  = 1'b1;
        cnt    = 64'd0;
        ts_exp = 64'd0;
        wfi_m  = 1'b0;
        for (int i = 0; i < 11; i++) begin
            step(1'b0, 1'b1, 8'(i), 64'd0, 1'b0);
            checks++;
            if (bus.ctrl_rvalid !== 1'b1 || bus.ctrl_addr_error !== 1'b0 ||
                bus.ctrl_rdata !== ((i == 9) ? 64'd9 : 64'd0)) begin
                errors++;
                $display("FAIL reset_read_%0d: rvalid=%b err=%b rdata=%h expected rdata=%h", i,
                         bus.ctrl_rvalid, bus.ctrl_addr_error, bus.ctrl_rdata,
                         (i == 9) ? 64'd9 : 64'd0);
            end
        end
        step(1'b0, 1'b0, 8'd0, 64'd0, 1'b0);
        checks++;
        if (bus.ctrl_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL rvalid_drop: got %b expected 0", bus.ctrl_rvalid);
        end
    endtask

    task automatic test_write_addr();
        logic [63:0] ts_w;
        ts_w = cnt;
        step(1'b1, 1'b0, 8'd1, 64'h8000_1000, 1'b0);
        checks++;
        if (trace_start_addr !== 64'h8000_1000) begin
            errors++;
            $display("FAIL start_addr_out: got %h expected %h", trace_start_addr, 64'h8000_1000);
        end
        step(1'b0, 1'b1, 8'd1, 64'd0, 1'b0);
        checks++;
        if (bus.ctrl_rdata !== 64'h8000_1000) begin
            errors++;
            $display("FAIL start_addr_rd: got %h expected %h", bus.ctrl_rdata, 64'h8000_1000);
        end
        step(1'b0, 1'b1, 8'd10, 64'd0, 1'b0);
        checks++;
        if (bus.ctrl_rdata !== ts_w) begin
            errors++;
            $display("FAIL timestamp_rd: got %h expected %h", bus.ctrl_rdata, ts_w);
        end
        step(1'b1, 1'b0, 8'd3, 64'hDEAD_0000_BEEF_0000, 1'b0);
        step(1'b1, 1'b0, 8'd5, 64'h0000_0000_0000_1000, 1'b0);
        step(1'b1, 1'b0, 8'd7, 64'h0000_0000_0000_2000, 1'b0);
        step(1'b1, 1'b0, 8'd2, 64'h1, 1'b0);
        step(1'b1, 1'b0, 8'd6, 64'h1, 1'b0);
        checks++;
        if (trace_end_addr !== 64'hDEAD_0000_BEEF_0000 || range_lower !== 64'h1000 ||
            range_upper !== 64'h2000 || trace_end_en !== 1'b1 || range_upper_en !== 1'b1 ||
            range_lower_en !== 1'b0) begin
            errors++;
            $display("FAIL other_regs: end=%h lo=%h hi=%h een=%b len=%b uen=%b expected end=dead0000beef0000 lo=1000 hi=2000 een=1 len=0 uen=1",
                     trace_end_addr, range_lower, range_upper, trace_end_en, range_lower_en, range_upper_en);
        end
    endtask

    task automatic test_enable();
        step(1'b1, 1'b0, 8'd0, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0);
        checks++;
        if (trace_start_en !== 1'b0) begin
            errors++;
            $display("FAIL en_bit0_zero: got %b expected 0", trace_start_en);
        end
        step(1'b0, 1'b1, 8'd0, 64'd0, 1'b0);
        checks++;
        if (bus.ctrl_rdata !== 64'd0) begin
            errors++;
            $display("FAIL en_rd_zero: got %h expected 0", bus.ctrl_rdata);
        end
        step(1'b1, 1'b0, 8'd0, 64'h3, 1'b0);
        checks++;
        if (trace_start_en !== 1'b1) begin
            errors++;
            $display("FAIL en_bit0_one: got %b expected 1", trace_start_en);
        end
        step(1'b0, 1'b1, 8'd0, 64'd0, 1'b0);
        checks++;
        if (bus.ctrl_rdata !== 64'd1) begin
            errors++;
            $display("FAIL en_rd_one: got %h expected 1", bus.ctrl_rdata);
        end
    endtask

    task automatic test_read_old();
        step(1'b1, 1'b1, 8'd1, 64'h1234, 1'b0);
        checks++;
        if (bus.ctrl_rdata !== 64'h8000_1000 || trace_start_addr !== 64'h1234) begin
            errors++;
            $display("FAIL read_old: rdata=%h out=%h expected rdata=80001000 out=1234",
                     bus.ctrl_rdata, trace_start_addr);
        end
    endtask

    task automatic test_wrap();
        logic [63:0] exp_v [3];
        exp_v[0] = 64'hFFFF_FFFF_FFFF_FFFE;
        exp_v[1] = 64'hFFFF_FFFF_FFFF_FFFF;
        exp_v[2] = 64'h0;
        step(1'b1, 1'b0, 8'd9, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 8'd9, 64'd0, 1'b0);
            checks++;
            if (bus.ctrl_rdata !== exp_v[i]) begin
                errors++;
                $display("FAIL wrap_%0d: got %h expected %h", i, bus.ctrl_rdata, exp_v[i]);
            end
        end
    endtask

    task automatic test_wfi();
        step(1'b0, 1'b0, 8'd0, 64'd0, 1'b1);
        c_frz = cnt;
        checks++;
        if (wfi_stopped !== 1'b1 || clk_counter !== c_frz) begin
            errors++;
            $display("FAIL wfi_set: flag=%b cnt=%h expected flag=1 cnt=%h", wfi_stopped, clk_counter, c_frz);
        end
        step(1'b0, 1'b0, 8'd0, 64'd0, 1'b0);
        checks++;
        if (clk_counter !== c_frz) begin
            errors++;
            $display("FAIL wfi_freeze: got %h expected %h", clk_counter, c_frz);
        end
        step(1'b1, 1'b0, 8'd8, 64'd0, 1'b1);
        checks++;
        if (wfi_stopped !== 1'b1) begin
            errors++;
            $display("FAIL wfi_set_wins: got %b expected 1", wfi_stopped);
        end
        step(1'b1, 1'b0, 8'd8, 64'd0, 1'b0);
        checks++;
        if (wfi_stopped !== 1'b0 || clk_counter !== c_frz) begin
            errors++;
            $display("FAIL wfi_clear: flag=%b cnt=%h expected flag=0 cnt=%h", wfi_stopped, clk_counter, c_frz);
        end
        step(1'b0, 1'b0, 8'd0, 64'd0, 1'b0);
        checks++;
        if (clk_counter !== c_frz + 64'd1 || clk_counter !== cnt) begin
            errors++;
            $display("FAIL wfi_resume: got %h expected %h", clk_counter, c_frz + 64'd1);
        end
    endtask

    task automatic test_addr_error();
        logic [63:0] ts_prev;
        ts_prev = ts_exp;
        step(1'b1, 1'b1, 8'h20, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        checks++;
        if (bus.ctrl_addr_error !== 1'b1 || bus.ctrl_rvalid !== 1'b1 || bus.ctrl_rdata !== 64'd0) begin
            errors++;
            $display("FAIL bad_addr: err=%b rvalid=%b rdata=%h expected err=1 rvalid=1 rdata=0",
                     bus.ctrl_addr_error, bus.ctrl_rvalid, bus.ctrl_rdata);
        end
        step(1'b0, 1'b1, 8'd10, 64'd0, 1'b0);
        checks++;
        if (bus.ctrl_addr_error !== 1'b0 || bus.ctrl_rdata !== ts_prev || trace_start_addr !== 64'h1234 ||
            trace_start_en !== 1'b1 || wfi_stopped !== 1'b0 || range_lower_en !== 1'b0) begin
            errors++;
            $display("FAIL bad_addr_nochange: err=%b ts=%h tsa=%h en=%b wfi=%b expected err=0 ts=%h tsa=1234 en=1 wfi=0",
                     bus.ctrl_addr_error, bus.ctrl_rdata, trace_start_addr, trace_start_en, wfi_stopped, ts_prev);
        end
        step(1'b1, 1'b0, 8'd10, 64'h5555_5555_5555_5555, 1'b0);
        checks++;
        if (bus.ctrl_addr_error !== 1'b0) begin
            errors++;
            $display("FAIL ts_write_err: got %b expected 0", bus.ctrl_addr_error);
        end
        step(1'b0, 1'b1, 8'd10, 64'd0, 1'b0);
        checks++;
        if (bus.ctrl_rdata !== ts_exp || ts_exp === ts_prev) begin
            errors++;
            $display("FAIL ts_write_capture: got %h expected %h", bus.ctrl_rdata, ts_exp);
        end
    endtask

    task automatic test_reset_pending();
        bus.ctrl_write_enable = 1'b0;
        bus.ctrl_read_enable  = 1'b1;
        bus.ctrl_addr         = 8'd1;
        #3;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (bus.ctrl_rvalid !== 1'b0 || trace_start_addr !== 64'd0 || clk_counter !== 64'd0) begin
            errors++;
            $display("FAIL reset_pending: rvalid=%b tsa=%h cnt=%h expected all 0",
                     bus.ctrl_rvalid, trace_start_addr, clk_counter);
        end
        bus.ctrl_read_enable = 1'b0;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (bus.ctrl_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL reset_pending_after: got %b expected 0", bus.ctrl_rvalid);
        end
    endtask

    initial begin
        test_reset();
        test_write_addr();
        test_enable();
        test_read_old();
        test_wrap();
        test_wfi();
        test_addr_error();
        test_reset_pending();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cms_ctrl_regfile.md
Name: cms_ctrl_regfile

Overview:
- Responder side of the CMS control port. It decodes address/data writes issued by the host-side control driver and holds the resulting trace-trigger and address-range configuration.
- Serves read-back of every control register with fixed 1-cycle latency.
- Owns the free-running clock counter, the last-write timestamp and the sticky WFI-stopped flag.
- Sits between the host control interface and the CMS trace filter and trigger logic, which consume its configuration outputs.

Parameters:
ADDR_WIDTH, CTRL_ADDR_WIDTH (8), control address width
DATA_WIDTH, CTRL_DATA_WIDTH (64), control data width
CNT_WIDTH, CLK_COUNTER_WIDTH (64), clock counter / timestamp width
FREEZE_ON_WFI, 1, when 1 clk_counter holds while wfi_stopped=1

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
ctrl_addr  in  ADDR_WIDTH  register address (ctrl_addr_t encoding)
ctrl_wdata  in  DATA_WIDTH  write data
ctrl_write_enable  in  1  write strobe, one write per cycle
ctrl_read_enable  in  1  read strobe
ctrl_rdata  out  DATA_WIDTH  read data
ctrl_rvalid  out  1  1-cycle pulse, ctrl_rdata valid
ctrl_addr_error  out  1  1-cycle pulse, access to an undefined address
instr  in  32  committed instruction
instr_valid  in  1  instr qualifier
trace_start_en, trace_end_en  out  1  trigger enables
trace_start_addr, trace_end_addr  out  DATA_WIDTH  trigger addresses
range_lower_en, range_upper_en  out  1  bound enables
range_lower, range_upper  out  DATA_WIDTH  monitored range bounds
wfi_stopped  out  1  sticky WFI-seen flag
clk_counter  out  CNT_WIDTH  cycle counter

Behaviour:
- Reset (async assert, sync release): all outputs and registers are 0, and ctrl_rvalid/ctrl_addr_error are 0.
- Write, accepted on the clk edge when ctrl_write_enable=1. The new value is visible on outputs the next cycle.
  - *_ENABLED addresses take wdata[0]. Upper bits are ignored and read back as 0.
  - Address registers take the full DATA_WIDTH.
  - CLK_COUNTER loads wdata[CNT_WIDTH-1:0]. The load overrides the increment for that cycle.
  - WFI_STOPPED takes wdata[0], so writing 0 clears the flag and writing 1 sets it.
  - LAST_WRITE_TIMESTAMP is read-only. A write to it is ignored and raises no error.
  - An undefined address (value at or above 11) changes no state and pulses ctrl_addr_error the next cycle.
- Timestamp: every accepted write to a defined address captures the pre-increment clk_counter value of that cycle into last_write_ts. This includes the ignored write to LAST_WRITE_TIMESTAMP.
- Read: ctrl_read_enable=1 in cycle N produces ctrl_rvalid=1 and ctrl_rdata in cycle N+1.
  - Data is the register value before any same-cycle write (read-old).
  - CLK_COUNTER reads return the value at cycle N.
  - An undefined address returns 0 and pulses ctrl_addr_error.
  - Back-to-back reads are supported every cycle; there is no backpressure.
- Simultaneous read and write in the same cycle: both are performed. If both address undefined addresses, ctrl_addr_error pulses once.
- clk_counter increments by 1 every cycle and wraps from 2^CNT_WIDTH-1 to 0. It holds while FREEZE_ON_WFI=1 and wfi_stopped=1.
- wfi_stopped is set when instr_valid=1 and instr==WFI_INSTRUCTION (32'h10500073). If the set coincides with a clearing write, the set wins. The flag stays set until cleared by a write or reset.
- Mid-operation reset discards any pending read response, so ctrl_rvalid is 0 after reset.

Decomposition:
- continuous_monitoring_system_pkg provides ctrl_addr_t, CTRL_ADDR_WIDTH, CTRL_DATA_WIDTH, CLK_COUNTER_WIDTH and WFI_INSTRUCTION.
- Add NO_OF_CTRL_REGISTERS = 11 to the package for undefined-address detection.
- Add a ctrl_rsp_t struct {rdata, rvalid, addr_error} to the package.
- One sub-module: cms_clk_counter, handling increment, load, freeze and wrap.

Test Plan:
- Reset, then read all 11 addresses back-to-back -> each ctrl_rvalid one cycle after its request; rdata 0 for all except CLK_COUNTER, which equals the cycle index.
- Write TRIGGER_TRACE_START_ADDRESS=64'h8000_1000, then read it -> trace_start_addr=64'h8000_1000 the next cycle; read returns the same value; LAST_WRITE_TIMESTAMP returns the counter value at the write cycle.
- Write TRIGGER_TRACE_START_ADDRESS_ENABLED=64'hFFFF_FFFF_FFFF_FFFE -> trace_start_en=0 and read-back 0. Write 64'h3 -> trace_start_en=1 and read-back 1.
- Write CLK_COUNTER=64'hFFFF_FFFF_FFFF_FFFE -> counter reads ...FE, then ...FF, then 0, confirming wrap.
- Drive instr=32'h10500073 with instr_valid=1 -> wfi_stopped=1 and clk_counter frozen. In the same cycle as a second WFI, write WFI_STOPPED=0 -> flag stays 1. A later write of 0 -> flag 0 and the counter resumes.
- Read and write address 8'h20 in the same cycle -> single ctrl_addr_error pulse, rdata 0, no register changes. Assert rst_n=0 with a read pending -> ctrl_rvalid stays 0.
